fsm_seq_driver: RTL and testbench

//  Initiator that drives the 2-input control FSM (IDLE/S1/S2/ER) and checks it step by step.

---
 rtl/fsm_seq_driver_if.sv | 32 +++
 rtl/fsm_seq_driver.sv | 177 +++++++++++++++++
 tb/tb_fsm_seq_driver.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_seq_driver_if.sv
`default_nettype none
// ============================================================================
// Module : fsm_seq_driver_if
// Brief  : Command, FSM drive/monitor and status bundle for fsm_seq_driver.
// Rev    : 1.0  initial release
// ============================================================================
interface fsm_seq_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_target;
    logic       drv_i1;
    logic       drv_i2;
    logic       mon_o1;
    logic       mon_o2;
    logic       mon_err;
    logic [1:0] cur_state;
    logic       done;
    logic [1:0] status;
    logic [2:0] steps;

    // master: command issuer that also hosts the FSM under drive
    modport master (
        output cmd_valid, cmd_target, mon_o1, mon_o2, mon_err,
        input  cmd_ready, drv_i1, drv_i2, cur_state, done, status, steps
    );

    modport slave (
        input  cmd_valid, cmd_target, mon_o1, mon_o2, mon_err,
        output cmd_ready, drv_i1, drv_i2, cur_state, done, status, steps
    );
endinterface
`default_nettype wire

// File: rtl/fsm_seq_driver.sv
`default_nettype none
// ============================================================================
// Module : fsm_seq_driver
// Brief  : Steps the 2-input control FSM to a commanded state, checking each response.
// Rev    : 1.0  initial release
// ============================================================================
module fsm_seq_driver #(
    parameter int RESP_LAT  = 1,
    parameter int MAX_STEPS = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    fsm_seq_driver_if.slave bus
);
    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_S1   = 2'b01;
    localparam logic [1:0] c_ST_S2   = 2'b10;
    localparam logic [1:0] c_ST_ER   = 2'b11;

    localparam logic [2:0] c_W_CMD = 3'd0;
    localparam logic [2:0] c_DRIVE = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_CHECK = 3'd3;
    localparam logic [2:0] c_FIN   = 3'd4;

    localparam int                 c_LAT_W     = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
    localparam logic [c_LAT_W-1:0] c_LAT_LAST  = c_LAT_W'(RESP_LAT - 1);
    localparam logic [2:0]         c_MAX_STEPS = 3'(MAX_STEPS);

    function automatic logic [1:0] f_next(input logic [1:0] st, input logic [1:0] vec);
        logic [1:0] w_nxt;
        w_nxt = st;
        case (st)
            c_ST_IDLE: if (vec == 2'b11) w_nxt = c_ST_S1;   else if (vec == 2'b10) w_nxt = c_ST_ER;
            c_ST_S1:   if (vec == 2'b11) w_nxt = c_ST_S2;   else if (vec == 2'b01) w_nxt = c_ST_ER;
            c_ST_S2:   if (vec == 2'b10) w_nxt = c_ST_IDLE; else if (vec == 2'b00) w_nxt = c_ST_ER;
            default:   if (!vec[1])      w_nxt = c_ST_IDLE;
        endcase
        return w_nxt;
    endfunction

    // First vector of the shortest path; later vectors fall out of re-evaluating from the new state.
    function automatic logic [1:0] f_path(input logic [1:0] from, input logic [1:0] to);
        case (from)
            c_ST_IDLE: return (to == c_ST_ER) ? 2'b10 : 2'b11;
            c_ST_S1:   return (to == c_ST_ER) ? 2'b01 : 2'b11;
            c_ST_S2:   return (to == c_ST_ER) ? 2'b00 : 2'b10;
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] f_hold(input logic [1:0] st);
        case (st)
            c_ST_S2: return 2'b01;
            c_ST_ER: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [1:0]         r_cur;
    logic [1:0]         r_target;
    logic [1:0]         r_exp;
    logic [1:0]         r_drv;
    logic [2:0]         r_cnt;
    logic [2:0]         r_steps;
    logic [1:0]         r_status;
    logic [c_LAT_W-1:0] r_lat;

    logic               w_accept;
    logic [2:0]         w_mon;
    logic               w_mon_legal;
    logic [1:0]         w_mon_state;
    logic [1:0]         w_vec;
    logic [1:0]         w_cur_nxt;
    logic [1:0]         w_status_nxt;
    logic [2:0]         w_steps_nxt;

    assign w_accept = bus.cmd_valid && (r_state == c_W_CMD);
    assign w_vec    = f_path(r_cur, r_target);

    always_comb begin
        w_mon       = {bus.mon_o1, bus.mon_o2, bus.mon_err};
        w_mon_legal = 1'b1;
        w_mon_state = c_ST_IDLE;
        case (w_mon)
            3'b000:  w_mon_state = c_ST_IDLE;
            3'b100:  w_mon_state = c_ST_S1;
            3'b010:  w_mon_state = c_ST_S2;
            3'b111:  w_mon_state = c_ST_ER;
            default: w_mon_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_W_CMD;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_W_CMD: if (w_accept) w_state_nxt = (bus.cmd_target == r_cur) ? c_FIN : c_DRIVE;
            c_DRIVE: w_state_nxt = c_WAIT;
            c_WAIT:  if (r_lat == c_LAT_LAST) w_state_nxt = c_CHECK;
            c_CHECK: begin
                if (!w_mon_legal || (w_mon_state != r_exp) || (r_exp == r_target) ||
                    (r_cnt == c_MAX_STEPS))
                    w_state_nxt = c_FIN;
                else
                    w_state_nxt = c_DRIVE;
            end
            default: w_state_nxt = c_W_CMD;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (r_state == c_W_CMD);
        bus.done      = (r_state == c_FIN);
        bus.drv_i1    = r_drv[1];
        bus.drv_i2    = r_drv[0];
        bus.cur_state = r_cur;
        bus.status    = r_status;
        bus.steps     = r_steps;
        w_cur_nxt     = r_cur;
        w_status_nxt  = 2'b00;
        w_steps_nxt   = (r_state == c_W_CMD) ? 3'd0 : r_cnt;
        if (r_state == c_CHECK) begin
            if (!w_mon_legal) begin
                w_status_nxt = 2'b10;
            end else if (w_mon_state != r_exp) begin
                w_status_nxt = 2'b01;
                w_cur_nxt    = w_mon_state;
            end else begin
                w_cur_nxt    = r_exp;
                w_status_nxt = (r_exp == r_target) ? 2'b00 : 2'b11;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur    <= c_ST_IDLE;
            r_target <= c_ST_IDLE;
            r_exp    <= c_ST_IDLE;
            r_drv    <= 2'b00;
            r_cnt    <= 3'd0;
            r_steps  <= 3'd0;
            r_status <= 2'b00;
            r_lat    <= '0;
        end else begin
            r_cur <= w_cur_nxt;
            if (w_accept) begin
                r_target <= bus.cmd_target;
                r_cnt    <= 3'd0;
            end
            if (r_state == c_DRIVE) begin
                r_drv <= w_vec;
                r_exp <= f_next(r_cur, w_vec);
                r_cnt <= r_cnt + 3'd1;
                r_lat <= '0;
            end
            // The vector is presented for one cycle only, so the FSM takes exactly one step.
            if (r_state == c_WAIT) begin
                r_lat <= r_lat + 1'b1;
                if (r_lat == '0) r_drv <= f_hold(r_exp);
            end
            if ((w_state_nxt == c_FIN) && (r_state != c_FIN)) begin
                r_status <= w_status_nxt;
                r_steps  <= w_steps_nxt;
                r_drv    <= f_hold(w_cur_nxt);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fsm_seq_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_fsm_seq_driver
// Brief  : Drives three fsm_seq_driver instances against a model of the control FSM.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fsm_seq_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v;
    logic [2:0] cmd_valid_v;
    logic [2:0] force_en_v;
    logic [1:0] cmd_target_a [3];
    logic [2:0] force_val_a  [3];

    wire  [2:0] obs_ready;
    wire  [2:0] obs_done;
    wire  [1:0] obs_cur    [3];
    wire  [1:0] obs_status [3];
    wire  [1:0] obs_drv    [3];
    wire  [2:0] obs_steps  [3];
    wire  [1:0] plant_st   [3];

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;
    int acc_cyc;
    int done_cnt [3];
    int done_cyc [3];

    typedef struct { int k; logic [1:0] st; logic [2:0] sp; logic [1:0] cur; logic [1:0] drv; } exp_t;
    typedef struct { int k; logic [1:0] st; int c; } log_t;
    exp_t       sb_q [$];
    log_t       tr_q [$];
    logic [1:0] prev_pst [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int c_RL = (g == 1) ? 3 : 1;
        localparam int c_MS = (g == 2) ? 1 : 4;

        fsm_seq_driver_if bus ();
        wire        w_rst = rst_v[g];
        logic [1:0] r_pst;
        logic [2:0] w_code;

        fsm_seq_driver #(.RESP_LAT(c_RL), .MAX_STEPS(c_MS)) u_dut (
            .clk (clk),
            .rst (w_rst),
            .bus (bus.slave)
        );

        // Independent model of the control FSM being driven.
        always_ff @(posedge clk or posedge w_rst) begin
            if (w_rst) r_pst <= 2'b00;
            else case ({r_pst, bus.drv_i1, bus.drv_i2})
                4'b00_11: r_pst <= 2'b01;
                4'b00_10: r_pst <= 2'b11;
                4'b01_11: r_pst <= 2'b10;
                4'b01_01: r_pst <= 2'b11;
                4'b10_10: r_pst <= 2'b00;
                4'b10_00: r_pst <= 2'b11;
                4'b11_00, 4'b11_01: r_pst <= 2'b00;
                default: ;
            endcase
        end

        always_comb begin
            case (r_pst)
                2'b00:   w_code = 3'b000;
                2'b01:   w_code = 3'b100;
                2'b10:   w_code = 3'b010;
                default: w_code = 3'b111;
            endcase
            if (force_en_v[g]) w_code = force_val_a[g];
        end

        assign bus.cmd_valid  = cmd_valid_v[g];
        assign bus.cmd_target = cmd_target_a[g];
        assign bus.mon_o1     = w_code[2];
        assign bus.mon_o2     = w_code[1];
        assign bus.mon_err    = w_code[0];
        assign obs_ready[g]   = bus.cmd_ready;
        assign obs_done[g]    = bus.done;
        assign obs_cur[g]     = bus.cur_state;
        assign obs_status[g]  = bus.status;
        assign obs_steps[g]   = bus.steps;
        assign obs_drv[g]     = {bus.drv_i1, bus.drv_i2};
        assign plant_st[g]    = r_pst;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer and FSM-model transition log.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (obs_done[k]) begin
                exp_t e;
                done_cnt[k]++;
                done_cyc[k] = cyc;
                chk("done_expected", (sb_q.size() > 0) ? 8'd1 : 8'd0, 8'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("done_inst",   8'(k),             8'(e.k));
                    chk("status",      8'(obs_status[k]), 8'(e.st));
                    chk("steps",       8'(obs_steps[k]),  8'(e.sp));
                    chk("cur_state",   8'(obs_cur[k]),    8'(e.cur));
                    chk("drv_hold",    8'(obs_drv[k]),    8'(e.drv));
                end
            end
            if (plant_st[k] !== prev_pst[k]) tr_q.push_back('{k, plant_st[k], cyc});
            prev_pst[k] = plant_st[k];
        end
    end

    task automatic send(input int k, input logic [1:0] tgt);
        int b = 0;
        while (!obs_ready[k] && b < 50) begin @(negedge clk); b++; end
        chk("ready_before_cmd", 8'(obs_ready[k]), 8'd1);
        cmd_target_a[k] = tgt;
        cmd_valid_v[k]  = 1'b1;
        acc_cyc         = cyc;
        @(negedge clk);
        cmd_valid_v[k]  = 1'b0;
    endtask

    task automatic wait_sb();
        int b = 0;
        while (sb_q.size() > 0 && b < 60) begin @(negedge clk); b++; end
        chk("done_within_budget", 8'(sb_q.size()), 8'd0);
    endtask

    task automatic run(input int k, input logic [1:0] tgt, input logic [1:0] st,
                       input logic [2:0] sp, input logic [1:0] cur, input logic [1:0] drv);
        sb_q.push_back('{k, st, sp, cur, drv});
        send(k, tgt);
        wait_sb();
    endtask

    task automatic reset_inst(input int k);
        rst_v[k] = 1'b1;
        @(negedge clk);
        rst_v[k] = 1'b0;
        @(negedge clk);
    endtask

    // From IDLE: go to ER, then ER->S2 and check the model's trajectory and step spacing.
    task automatic er_to_s2(input int k, input int lat);
        run(k, 2'b11, 2'b00, 3'd1, 2'b11, 2'b10);
        tr_q.delete();
        run(k, 2'b10, 2'b00, 3'd3, 2'b10, 2'b01);
        chk("er_s2_transitions", 8'(tr_q.size()), 8'd3);
        if (tr_q.size() == 3) begin
            chk("er_s2_path0", 8'(tr_q[0].st), 8'd0);
            chk("er_s2_path1", 8'(tr_q[1].st), 8'd1);
            chk("er_s2_path2", 8'(tr_q[2].st), 8'd2);
            chk("step_spacing1", 8'(tr_q[1].c - tr_q[0].c), 8'(lat + 2));
            chk("step_spacing2", 8'(tr_q[2].c - tr_q[1].c), 8'(lat + 2));
        end
    endtask

    initial begin
        int d0;
        rst_v       = 3'b111;
        cmd_valid_v = 3'b000;
        force_en_v  = 3'b000;
        for (int k = 0; k < 3; k++) begin
            cmd_target_a[k] = 2'b00;
            force_val_a[k]  = 3'b000;
            done_cnt[k]     = 0;
            prev_pst[k]     = 2'b00;
        end
        repeat (2) @(negedge clk);
        rst_v = 3'b000;
        @(negedge clk);

        chk("rst_ready",  8'(obs_ready[0]),  8'd1);
        chk("rst_done",   8'(obs_done[0]),   8'd0);
        chk("rst_cur",    8'(obs_cur[0]),    8'd0);
        chk("rst_drv",    8'(obs_drv[0]),    8'd0);
        chk("rst_status", 8'(obs_status[0]), 8'd0);
        chk("rst_steps",  8'(obs_steps[0]),  8'd0);

        // IDLE -> S2 via 11,11
        tr_q.delete();
        run(0, 2'b10, 2'b00, 3'd2, 2'b10, 2'b01);
        chk("idle_s2_transitions", 8'(tr_q.size()), 8'd2);
        chk("drv_after_done", 8'(obs_drv[0]), 8'b01);

        // S2 -> IDLE, with stray cmd_valid while busy
        sb_q.push_back('{0, 2'b00, 3'd1, 2'b00, 2'b00});
        send(0, 2'b00);
        cmd_target_a[0] = 2'b11;
        cmd_valid_v[0]  = 1'b1;
        repeat (2) @(negedge clk);
        cmd_valid_v[0]  = 1'b0;
        wait_sb();
        chk("s2_idle_latency", 8'(done_cyc[0] - acc_cyc), 8'd4);
        d0 = done_cnt[0];
        repeat (4) @(negedge clk);
        chk("busy_cmd_ignored", 8'(done_cnt[0] - d0), 8'd0);

        // Forced ER response while heading to S1
        force_val_a[0] = 3'b111;
        force_en_v[0]  = 1'b1;
        run(0, 2'b01, 2'b01, 3'd1, 2'b11, 2'b10);
        force_en_v[0]  = 1'b0;

        // Illegal code keeps cur_state; then a no-op command
        force_val_a[0] = 3'b110;
        force_en_v[0]  = 1'b1;
        run(0, 2'b00, 2'b10, 3'd1, 2'b11, 2'b10);
        force_en_v[0]  = 1'b0;
        run(0, 2'b11, 2'b00, 3'd0, 2'b11, 2'b10);
        chk("noop_latency", 8'(done_cyc[0] - acc_cyc), 8'd1);

        reset_inst(0);
        er_to_s2(0, 1);
        er_to_s2(1, 3);

        // Step limit of one
        run(2, 2'b10, 2'b11, 3'd1, 2'b01, 2'b00);
        send(2, 2'b00);
        @(negedge clk);
        rst_v[2] = 1'b1;
        @(negedge clk);
        chk("midrst_drv",    8'(obs_drv[2]),    8'd0);
        chk("midrst_cur",    8'(obs_cur[2]),    8'd0);
        chk("midrst_status", 8'(obs_status[2]), 8'd0);
        chk("midrst_steps",  8'(obs_steps[2]),  8'd0);
        rst_v[2] = 1'b0;
        d0 = done_cnt[2];
        repeat (6) @(negedge clk);
        chk("midrst_no_done", 8'(done_cnt[2] - d0), 8'd0);
        chk("midrst_ready",   8'(obs_ready[2]),     8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
